// File: rtl/vm_pkg.sv
// Shared definitions for the voting-machine ballot driver, the machine itself and its benches.
package vm_pkg;

    localparam int NUM_CAND = 4;
    localparam int CNT_W    = 8;

    typedef logic [1:0] cand_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        SETTLE  = 3'd2,
        RELEASE = 3'd3,
        GAP     = 3'd4
    } ballot_state_t;

    function automatic logic [NUM_CAND-1:0] cand_onehot(input cand_t c);
        return 4'b0001 << c;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ballot_timer.sv
// Loadable down-counter for the ballot driver; o_done is high while the count sits at zero.
module ballot_timer #(
    parameter int W = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Count register: load wins, otherwise decrement and park at zero.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/vote_ballot_driver.sv
// Command front end for the voting machine panel: turns vote/read commands into clean,
// correctly timed mode/button sequences and returns sampled tallies on a response strobe.
module vote_ballot_driver #(
    parameter int PRESS_CYCLES  = 11,
    parameter int GAP_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = vm_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_read,
    input  logic [1:0]       cmd_cand,
    output logic             mode,
    output logic             button1,
    output logic             button2,
    output logic             button3,
    output logic             button4,
    input  logic [CNT_W-1:0] led,
    output logic             rsp_valid,
    output logic [CNT_W-1:0] rsp_data,
    output logic             busy
);
    import vm_pkg::*;

    localparam int TW = $clog2(max3(PRESS_CYCLES, SETTLE_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TW-1:0] PRESS_LOAD  = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD    = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
    localparam logic          HAS_GAP     = (GAP_CYCLES > 0);

    ballot_state_t     r_state;
    ballot_state_t     w_state_next;
    cand_t             r_cand;
    cand_t             w_cand_next;
    logic              r_mode;
    logic [3:0]        r_buttons;
    logic              r_rsp_valid;
    logic [CNT_W-1:0]  r_rsp_data;

    logic              w_xfer;
    logic              w_load;
    logic [TW-1:0]     w_load_val;
    logic              w_done;
    logic              w_mode_next;
    logic [3:0]        w_buttons_next;
    logic              w_rsp_valid_next;
    logic [CNT_W-1:0]  w_rsp_data_next;

    assign w_xfer = cmd_valid & cmd_ready;

    ballot_timer #(.W(TW)) u_timer (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Next-state and timer-load decode.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        case (r_state)
            IDLE: begin
                if (w_xfer && cmd_read) begin
                    w_state_next = SETTLE;
                    w_load       = 1'b1;
                    w_load_val   = SETTLE_LOAD;
                end else if (w_xfer) begin
                    w_state_next = PRESS;
                    w_load       = 1'b1;
                    w_load_val   = PRESS_LOAD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            PRESS: begin
                if (w_done) begin
                    w_state_next = HAS_GAP ? GAP : IDLE;
                    w_load       = HAS_GAP;
                    w_load_val   = GAP_LOAD;
                end else begin
                    w_state_next = PRESS;
                end
            end
            SETTLE: begin
                if (w_done) begin
                    w_state_next = RELEASE;
                end else begin
                    w_state_next = SETTLE;
                end
            end
            RELEASE: begin
                w_state_next = HAS_GAP ? GAP : IDLE;
                w_load       = HAS_GAP;
                w_load_val   = GAP_LOAD;
            end
            GAP: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = GAP;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the panel pins come straight off flops.
    always_comb begin
        w_cand_next      = w_xfer ? cand_t'(cmd_cand) : r_cand;
        w_mode_next      = 1'b0;
        w_buttons_next   = 4'b0000;
        w_rsp_valid_next = 1'b0;
        case (w_state_next)
            PRESS: begin
                w_buttons_next = cand_onehot(w_cand_next);
            end
            SETTLE: begin
                w_mode_next    = 1'b1;
                w_buttons_next = cand_onehot(w_cand_next);
            end
            RELEASE: begin
                w_mode_next      = 1'b1;
                w_rsp_valid_next = 1'b1;
            end
            default: begin
                w_mode_next = 1'b0;
            end
        endcase
        // led is only trustworthy on the last held cycle, while the button still selects it.
        if ((r_state == SETTLE) && w_done) begin
            w_rsp_data_next = led;
        end else begin
            w_rsp_data_next = r_rsp_data;
        end
    end

    // State, captured command and registered panel/response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cand      <= 2'd0;
            r_mode      <= 1'b0;
            r_buttons   <= 4'b0000;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cand      <= w_cand_next;
            r_mode      <= w_mode_next;
            r_buttons   <= w_buttons_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_data  <= w_rsp_data_next;
        end
    end

    assign cmd_ready = (r_state == IDLE) & ~reset;
    assign busy      = (r_state != IDLE);
    assign mode      = r_mode;
    assign button1   = r_buttons[0];
    assign button2   = r_buttons[1];
    assign button3   = r_buttons[2];
    assign button4   = r_buttons[3];
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_vote_ballot_driver.sv
// Bench for vote_ballot_driver against a small behavioural voting machine; read responses
// are checked by a scoreboard queue, panel timing and invariants by per-cycle checks.
module tb_vote_ballot_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_read = 1'b0;
    logic [1:0] cmd_cand = 2'd0;
    logic       mode;
    logic       button1, button2, button3, button4;
    logic [7:0] led;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic [3:0] btns;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rsp    = 0;
    int cyc      = 0;
    logic [7:0] exp_q [$];

    vote_ballot_driver dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_cand  (cmd_cand),
        .mode      (mode),
        .button1   (button1),
        .button2   (button2),
        .button3   (button3),
        .button4   (button4),
        .led       (led),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    assign btns = {button4, button3, button2, button1};

    // Behavioural machine: a press counts when released after more than 10 held cycles in mode 0.
    logic [7:0] tally [4];
    int         hold  [4];
    always @(posedge clock) begin
        for (int c = 0; c < 4; c++) begin
            if (reset) begin
                tally[c] <= 8'd0;
                hold[c]  <= 0;
            end else if (btns[c]) begin
                hold[c] <= hold[c] + 1;
            end else begin
                if (hold[c] > 10 && !mode) tally[c] <= tally[c] + 8'd1;
                hold[c] <= 0;
            end
        end
    end
    always_comb begin
        led = 8'd0;
        for (int c = 0; c < 4; c++) if (mode && btns[c]) led = tally[c];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: every response strobe consumes one expected tally.
    always @(negedge clock) begin
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp at cycle %0d: got data %0h, expected no response", cyc, rsp_data);
            end else begin
                chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Per-cycle panel invariants.
    logic       prev_mode = 1'b0;
    logic [3:0] prev_btns = 4'b0000;
    always @(negedge clock) begin
        chk("onehot0_buttons", {31'd0, $onehot0(btns)}, 32'd1);
        if (mode !== prev_mode) chk("button_on_mode_change", {28'd0, prev_btns}, 32'd0);
        if (rsp_valid === 1'b1) chk("rsp_outside_release", {27'd0, mode, btns}, 32'h10);
        if (cmd_ready === 1'b1) chk("ready_while_busy", {31'd0, busy}, 32'd0);
        prev_mode = mode;
        prev_btns = btns;
    end

    task automatic issue(input logic rd, input logic [1:0] c, output int t);
        int w = 0;
        @(negedge clock);
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_ready_timeout at cycle %0d: got ready=%0b, expected 1", cyc, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_cand  = c;
        t         = cyc;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] c, input logic [7:0] exp);
        int t;
        exp_q.push_back(exp);
        issue(1'b1, c, t);
    endtask

    task automatic drain();
        int w = 0;
        do begin
            @(negedge clock);
            w++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && w < 200);
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        int t;
        int base;

        // 1: reset held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("reset_outputs", {25'd0, mode, btns, rsp_valid, cmd_ready}, 32'd0);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
        chk("rsp_data_reset", {24'd0, rsp_data}, 32'd0);

        // 2: vote cand0 timing, then read it back
        issue(1'b0, 2'd0, t);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            chk("t2_button1", {31'd0, button1}, (k <= 11) ? 32'd1 : 32'd0);
            chk("t2_cmd_ready", {31'd0, cmd_ready}, (k == 16) ? 32'd1 : 32'd0);
        end
        do_read(2'd0, 8'd1);
        drain();

        // 3: back-to-back votes, then three reads
        base = n_rsp;
        issue(1'b0, 2'd1, t);
        issue(1'b0, 2'd1, t);
        issue(1'b0, 2'd2, t);
        do_read(2'd1, 8'd2);
        do_read(2'd2, 8'd1);
        do_read(2'd3, 8'd0);
        drain();
        chk("t3_strobes", n_rsp - base, 32'd3);

        // 4: cmd_valid held with toggling fields while busy
        issue(1'b0, 2'd3, t);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            chk("t4_buttons", {28'd0, btns}, (k <= 11) ? 32'h8 : 32'h0);
            cmd_valid = 1'b1;
            cmd_cand  = k[1:0];
            cmd_read  = k[0];
        end
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("t4_idle", {31'd0, busy}, 32'd0);
        @(negedge clock);
        chk("t4_no_extra_cmd", {27'd0, busy, btns}, 32'd0);
        do_read(2'd3, 8'd1);
        do_read(2'd0, 8'd1);
        drain();

        // 5: reset in the 5th PRESS cycle
        base = n_rsp;
        issue(1'b0, 2'd0, t);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_abort_outputs", {25'd0, mode, btns, rsp_valid, cmd_ready}, 32'd0);
        chk("t5_abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("t5_no_rsp", n_rsp - base, 32'd0);
        do_read(2'd0, 8'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no end of test, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
